// File: rtl/reg_file_reader.sv
// Core register file with a dual-operand, valid/ready read port and a one-deep registered response.
// Each operand has its own capture lane that snapshots, holds and tracks staleness of its register.

module reg_file_reader_lane #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_accept,
  input  logic                           i_consume,
  input  logic                           i_hold,
  input  logic                           i_wr_en,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]              i_wr_data,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic [NREGS-1:0][DATA_W-1:0]   i_regs,
  output logic [DATA_W-1:0]              o_data,
  output logic                           o_stale
);
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_stale;
  logic [DATA_W-1:0] w_snap;
  logic              w_wr_hit;

  // Same-cycle write is forwarded so the requester sees it without a stall.
  always_comb begin
    w_snap = '0;
    if (i_addr != '0)
      w_snap = (i_wr_en && (i_wr_addr == i_addr)) ? i_wr_data : i_regs[i_addr];
  end

  assign w_wr_hit = i_wr_en && (i_wr_addr == r_addr) && (r_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_stale <= 1'b0;
    end else if (i_accept) begin
      r_addr  <= i_addr;
      r_data  <= w_snap;
      r_stale <= 1'b0;
    end else if (i_consume) begin
      r_stale <= 1'b0;
    end else if (i_hold && w_wr_hit) begin
      r_stale <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_stale = r_stale;
endmodule

module reg_file_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic              o_rd_rsp_valid,
  input  logic              i_rd_rsp_ready,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_stale_a,
  output logic              o_rd_stale_b
);
  localparam int NOPS = 2;

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic                         r_rsp_valid;
  logic                         w_accept;
  logic                         w_consume;
  logic                         w_hold;
  logic [NOPS-1:0][ADDR_W-1:0]  w_addr;
  logic [NOPS-1:0][DATA_W-1:0]  w_data;
  logic [NOPS-1:0]              w_stale;

  assign o_rd_req_ready = !r_rsp_valid || i_rd_rsp_ready;
  assign w_accept       = i_rd_req_valid && o_rd_req_ready;
  assign w_consume      = r_rsp_valid && i_rd_rsp_ready;
  assign w_hold         = r_rsp_valid && !i_rd_rsp_ready;

  // R0 is never written, so its storage stays at the reset value of zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_regs <= '0;
    else if (i_wr_en && (i_wr_addr != '0))
      r_regs[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rsp_valid <= 1'b0;
    else if (w_accept)
      r_rsp_valid <= 1'b1;
    else if (w_consume)
      r_rsp_valid <= 1'b0;
  end

  assign w_addr = {i_rd_addr_b, i_rd_addr_a};

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    reg_file_reader_lane #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_accept  (w_accept),
      .i_consume (w_consume),
      .i_hold    (w_hold),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_addr    (w_addr[g]),
      .i_regs    (r_regs),
      .o_data    (w_data[g]),
      .o_stale   (w_stale[g])
    );
  end

  assign o_rd_rsp_valid = r_rsp_valid;
  assign o_rd_data_a    = w_data[0];
  assign o_rd_data_b    = w_data[1];
  assign o_rd_stale_a   = w_stale[0];
  assign o_rd_stale_b   = w_stale[1];
endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader: a posedge reference model queues expected responses,
// a negedge monitor compares whatever the DUT presents.

module tb_reg_file_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  addr_a, addr_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] data_a, data_b;
  logic        stale_a, stale_b;

  always #5 clk = ~clk;

  reg_file_reader #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_rd_req_valid (req_valid),
    .o_rd_req_ready (req_ready),
    .i_rd_addr_a    (addr_a),
    .i_rd_addr_b    (addr_b),
    .o_rd_rsp_valid (rsp_valid),
    .i_rd_rsp_ready (rsp_ready),
    .o_rd_data_a    (data_a),
    .o_rd_data_b    (data_b),
    .o_rd_stale_a   (stale_a),
    .o_rd_stale_b   (stale_b)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state
  int          m_regs[8];
  bit          m_init = 0;
  bit          m_held = 0;
  bit          m_sa = 0, m_sb = 0;
  int          m_cap_a = 0, m_cap_b = 0;
  logic [15:0] m_last_a = '0, m_last_b = '0;
  bit          m_acc;
  exp_t        m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] snap(input int a);
    if (a == 0) return 16'h0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return 16'(m_regs[a]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sbq.delete();
      m_init = 1;
      m_held = 0;
      m_sa = 0;
      m_sb = 0;
      m_cap_a = 0;
      m_cap_b = 0;
      m_last_a = '0;
      m_last_b = '0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
    end else if (m_init) begin
      m_acc = req_valid && (!m_held || rsp_ready);
      if (m_held && !rsp_ready && wr_en && wr_addr != 0) begin
        if (int'(wr_addr) == m_cap_a) m_sa = 1;
        if (int'(wr_addr) == m_cap_b) m_sb = 1;
      end
      if (m_acc) begin
        m_e.a = snap(int'(addr_a));
        m_e.b = snap(int'(addr_b));
        sbq.push_back(m_e);
        m_last_a = m_e.a;
        m_last_b = m_e.b;
        m_cap_a = int'(addr_a);
        m_cap_b = int'(addr_b);
        m_sa = 0;
        m_sb = 0;
        m_held = 1;
      end else if (m_held && rsp_ready) begin
        m_held = 0;
        m_sa = 0;
        m_sb = 0;
      end
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = int'(wr_data);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_held));
      chk("req_ready", 32'(req_ready), 32'(!m_held || rsp_ready));
      chk("stale_a", 32'(stale_a), 32'(m_sa));
      chk("stale_b", 32'(stale_b), 32'(m_sb));
      if (rsp_valid && m_held && sbq.size() > 0) begin
        chk("data_a", 32'(data_a), 32'(sbq[0].a));
        chk("data_b", 32'(data_b), 32'(sbq[0].b));
        if (rsp_ready) void'(sbq.pop_front());
      end else begin
        chk("idle_data_a", 32'(data_a), 32'(m_last_a));
        chk("idle_data_b", 32'(data_b), 32'(m_last_b));
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wr_en = 0;
    req_valid = 0;
  endtask

  task automatic req(input logic [2:0] a, input logic [2:0] b);
    req_valid = 1;
    addr_a = a;
    addr_b = b;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    req_valid = 0; addr_a = 0; addr_b = 0; rsp_ready = 1;
    // Write during reset must be dropped
    tick(1);
    wr(3'd4, 16'hAAAA);
    tick(1);
    rst = 0; idle();
    // Reset-state read
    req(3'd3, 3'd5); tick(1); idle();
    tick(1);
    // Plain write then read
    wr(3'd3, 16'h1234); tick(1); idle();
    req(3'd3, 3'd0); tick(1); idle();
    // Bypass, same address on both operands
    wr(3'd5, 16'hBEEF); req(3'd5, 3'd5); tick(1); idle();
    // R0 discard
    wr(3'd0, 16'hFFFF); tick(1); idle();
    req(3'd0, 3'd4); tick(1); idle();
    // Hold with stale on A only
    wr(3'd2, 16'h0011); tick(1); idle();
    rsp_ready = 0;
    req(3'd2, 3'd4); tick(1); idle();
    wr(3'd2, 16'h0022); tick(1); idle();
    req(3'd1, 3'd1); tick(2);
    rsp_ready = 1; tick(1); idle();
    tick(1);
    // Stream four back-to-back reads
    for (int i = 1; i <= 4; i++) begin
      req(3'(i), 3'(8 - i)); tick(1);
    end
    idle(); tick(1);
    // Reset in the middle of a held response
    wr(3'd6, 16'h6666); tick(1); idle();
    rsp_ready = 0; req(3'd6, 3'd3); tick(1); idle();
    wr(3'd3, 16'h7777); tick(1); idle();
    rst = 1; tick(1); rst = 0; rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req(3'(i), 3'(7 - i)); tick(1);
    end
    idle(); tick(1);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (!(req_valid && !req_ready)) begin
        req_valid = ($urandom_range(0, 3) != 0);
        addr_a    = 3'($urandom_range(0, 7));
        addr_b    = ($urandom_range(0, 4) == 0) ? addr_a : 3'($urandom_range(0, 7));
      end
      tick(1);
    end
    rst = 0; idle(); rsp_ready = 1;
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
